alu_exec_unit: RTL and testbench

Parametrised, handshaked integer execute stage for the RV32I/RV64I ALU path. Decodes OP (R-type) and OP-IMM (I-type) instructions, including SUB/SRA/SLT/SLTU, into an internal ALU operation and computes the result. Supports single-cycle or iterative (1 bit/cycle) shifting. Sits between register-read and writeback, with valid/ready on both sides.

---
 rtl/alu_pkg.sv | 12 +
 rtl/alu_op_decoder.sv | 43 ++++
 rtl/alu_exec_unit.sv | 97 +++++++++
 tb/tb_alu_exec_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU execute stage
// Holds the decoded ALU operation enum, FSM state enum, opcode and funct7 constants.
package alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU, OP_ILL
  } alu_op_t;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: combinational decode of OP / OP-IMM fields into an ALU operation
// Ports: opcode, funct3, funct7, imm (I-immediate low 12 bits) in; op (alu_op_t), is_shift out.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [11:0] imm,
  output alu_op_t     op,
  output logic        is_shift
);
  localparam int SW = $clog2(XLEN);
  logic r_type, i_type, alt, shamt_bad;
  alu_op_t base_op;
  assign r_type = opcode == OPC_OP;
  assign i_type = opcode == OPC_OP_IMM;
  // R-type picks the alternate op from funct7, I-type shifts from imm[10]
  assign alt = r_type ? funct7 == F7_ALT : imm[10];
  // I-type shifts: imm bits above the shamt field must be clear, except the SRAI select bit
  assign shamt_bad = |((imm & 12'hBFF) >> SW);
  always_comb
    case (funct3)
      3'b000:  base_op = alt && r_type ? OP_SUB : OP_ADD;
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = alt ? OP_SRA : OP_SRL;
      3'b110:  base_op = OP_OR;
      default: base_op = OP_AND;
    endcase
  always_comb begin
    op = base_op;
    if (!(r_type || i_type)) op = OP_ILL;
    else if (r_type && funct7 != F7_BASE &&
             !(funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) op = OP_ILL;
    else if (i_type && funct3[1:0] == 2'b01 && shamt_bad) op = OP_ILL;
  end
  assign is_shift = op inside {OP_SLL, OP_SRL, OP_SRA};
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked RV32I/RV64I integer execute stage with barrel or iterative shifter
// Ports: clk, rst_n (async active-low), flush (sync abort);
//        in_valid/in_ready with opcode, funct3, funct7, rs1_val, rs2_val, imm;
//        out_valid/out_ready with result and illegal.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER_SHIFT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  state_t state, next_state;
  alu_op_t op, op_q;
  logic is_shift, accept, go_shift, ill_q;
  logic [XLEN-1:0] b, alu_res, work, shifted, res_q;
  logic [SW-1:0] shamt;
  logic [CW-1:0] cnt;
  alu_op_decoder #(.XLEN(XLEN)) u_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .imm      (imm[11:0]),
    .op       (op),
    .is_shift (is_shift)
  );
  assign b = opcode == OPC_OP ? rs2_val : imm;
  assign shamt = b[SW-1:0];
  assign accept = in_valid && in_ready;
  assign go_shift = ITER_SHIFT != 0 && is_shift && shamt != '0;
  // One-bit step of the iterative shifter; SRA refills from the sign bit
  assign shifted = op_q == OP_SLL ? work << 1 : {op_q == OP_SRA && work[XLEN-1], work[XLEN-1:1]};
  always_comb
    case (op)
      OP_ADD:  alu_res = rs1_val + b;
      OP_SUB:  alu_res = rs1_val - b;
      OP_XOR:  alu_res = rs1_val ^ b;
      OP_OR:   alu_res = rs1_val | b;
      OP_AND:  alu_res = rs1_val & b;
      OP_SLL:  alu_res = rs1_val << shamt;
      OP_SRL:  alu_res = rs1_val >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(rs1_val) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1_val < b};
      default: alu_res = '0;
    endcase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= next_state;
  // The counter holds the remaining shift steps; the step that empties it lands in DONE
  always_comb
    next_state = flush ? S_IDLE
               : accept ? (go_shift ? S_SHIFT : S_DONE)
               : (state == S_SHIFT && cnt == CW'(1)) ? S_DONE
               : (state == S_DONE && out_ready) ? S_IDLE
               : state;
  always_comb begin
    in_ready = !flush && (state == S_IDLE || (state == S_DONE && out_ready));
    out_valid = state == S_DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      op_q <= OP_ADD;
      work <= '0;
      cnt <= '0;
      res_q <= '0;
      ill_q <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      work <= rs1_val;
      cnt <= CW'(shamt);
      res_q <= go_shift ? res_q : alu_res;
      ill_q <= op == OP_ILL;
    end else if (state == S_SHIFT && !flush) begin
      work <= shifted;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) res_q <= shifted;
    end
  assign result = res_q;
  assign illegal = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit (iterative and barrel instances)
module tb_alu_exec_unit;
  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, OPL = 7'b0000011;
  localparam logic [6:0] FB = 7'b0000000, FA = 7'b0100000;
  typedef struct {logic [31:0] res; logic ill;} exp_t;
  logic clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 1, bar_valid = 0;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic [31:0] rs1_val = '0, rs2_val = '0, imm = '0;
  logic in_ready, out_valid, illegal, bar_in_ready, bar_out_valid, bar_illegal;
  logic [31:0] result, bar_result;
  int tests = 0, fails = 0, last_wait = 0;
  exp_t exp_q[$], bar_q[$];

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32), .ITER_SHIFT(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .result(result), .illegal(illegal)
  );

  alu_exec_unit #(.XLEN(32), .ITER_SHIFT(0)) bar (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(bar_valid), .in_ready(bar_in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm(imm), .out_valid(bar_out_valid), .out_ready(1'b1), .result(bar_result), .illegal(bar_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitors sample mid-cycle, after the bench has set this cycle's out_ready
  always @(negedge clk) begin
    #3;
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      if (exp_q.size() == 0) chk("unexpected_output", 32'(out_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("result", result, e.res);
        chk("illegal", 32'(illegal), 32'(e.ill));
      end
    end
  end

  always @(negedge clk) begin
    #3;
    if (rst_n && bar_out_valid) begin
      exp_t e;
      if (bar_q.size() == 0) chk("bar_unexpected_output", 32'(bar_out_valid), 32'd0);
      else begin
        e = bar_q.pop_front();
        chk("bar_result", bar_result, e.res);
        chk("bar_illegal", 32'(bar_illegal), 32'(e.ill));
      end
    end
  end

  task automatic run(input string name, input logic [6:0] opc, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] im, input logic [31:0] er, input logic ei,
                     input int el, input bit track, input logic ordy);
    int lat;
    last_wait = 0;
    @(negedge clk);
    opcode = opc; funct3 = f3; funct7 = f7; rs1_val = a; rs2_val = b; imm = im;
    in_valid = 1; out_ready = ordy;
    #1;
    while (!in_ready && last_wait < 100) begin
      @(negedge clk);
      #1;
      last_wait++;
    end
    if (!in_ready) chk({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    if (track) exp_q.push_back('{er, ei});
    #1 in_valid = 0;
    if (track) begin
      lat = 1;
      while (!out_valid && lat < 100) begin
        chk({name, "_in_ready_busy"}, 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'(el));
    end
  endtask

  task automatic bar_run(input string name, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] er);
    @(negedge clk);
    opcode = opc; funct3 = f3; funct7 = f7; rs1_val = a; rs2_val = b; imm = im;
    bar_valid = 1;
    @(posedge clk);
    bar_q.push_back('{er, 1'b0});
    #1 bar_valid = 0;
    chk({name, "_latency"}, 32'(bar_out_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int n;
    #1 rst_n = 0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    run("sub", OPR, 3'd0, FA, 32'd5, 32'd7, 32'd0, 32'hFFFFFFFE, 1'b0, 1, 1, 1);
    run("add", OPR, 3'd0, FB, 32'd5, 32'd7, 32'd0, 32'd12, 1'b0, 1, 1, 1);
    run("addi_wrap", OPI, 3'd0, FA, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd0, 1'b0, 1, 1, 1);
    run("srai", OPI, 3'd5, FB, 32'h80000000, 32'd0, 32'h404, 32'hF8000000, 1'b0, 5, 1, 1);
    run("srli", OPI, 3'd5, FB, 32'h80000000, 32'd0, 32'h4, 32'h08000000, 1'b0, 5, 1, 1);
    run("sll_r", OPR, 3'd1, FB, 32'd1, 32'h21, 32'd0, 32'd2, 1'b0, 2, 1, 1);
    run("slli_zero", OPI, 3'd1, FB, 32'h1234, 32'd0, 32'd0, 32'h1234, 1'b0, 1, 1, 1);
    run("sra_r", OPR, 3'd5, FA, 32'hFFFFFF00, 32'd8, 32'd0, 32'hFFFFFFFF, 1'b0, 9, 1, 1);
    run("slt", OPR, 3'd2, FB, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd1, 1'b0, 1, 1, 1);
    run("sltu", OPR, 3'd3, FB, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 1'b0, 1, 1, 1);
    run("slti", OPI, 3'd2, FB, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd1, 1'b0, 1, 1, 1);
    run("xor", OPR, 3'd4, FB, 32'hF0F0, 32'h0FF0, 32'd0, 32'hFF00, 1'b0, 1, 1, 1);
    run("or", OPR, 3'd6, FB, 32'hF0F0, 32'h0FF0, 32'd0, 32'hFFF0, 1'b0, 1, 1, 1);
    run("and", OPR, 3'd7, FB, 32'hF0F0, 32'h0FF0, 32'd0, 32'h00F0, 1'b0, 1, 1, 1);
    run("ill_f7", OPR, 3'd0, 7'b0000001, 32'd5, 32'd7, 32'd0, 32'd0, 1'b1, 1, 1, 1);
    run("ill_opcode", OPL, 3'd0, FB, 32'd5, 32'd7, 32'd0, 32'd0, 1'b1, 1, 1, 1);
    run("ill_slli", OPI, 3'd1, FB, 32'd1, 32'd0, 32'h21, 32'd0, 1'b1, 1, 1, 1);
    run("ill_xor_alt", OPR, 3'd4, FA, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1, 1, 1, 1);
    // Backpressure: hold out_ready low, then release together with a new request
    repeat (2) @(negedge clk);
    run("bp_add", OPR, 3'd0, FB, 32'd1, 32'd2, 32'd0, 32'd3, 1'b0, 1, 1, 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", result, 32'd3);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    run("bp_release", OPR, 3'd0, FB, 32'd10, 32'd20, 32'd0, 32'd30, 1'b0, 1, 1, 1);
    chk("bp_same_cycle_accept", 32'(last_wait), 32'd0);
    // Back-to-back throughput
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      opcode = OPR; funct3 = 3'd0; funct7 = FB; rs1_val = 32'(i); rs2_val = 32'd100;
      in_valid = 1;
      #1;
      chk("tput_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      exp_q.push_back('{32'(100 + i), 1'b0});
    end
    @(negedge clk);
    in_valid = 0;
    // Flush in the middle of a 20-step shift
    run("flush_op", OPI, 3'd1, FB, 32'd1, 32'd0, 32'd20, 32'd0, 1'b0, 0, 0, 1);
    repeat (3) @(negedge clk);
    flush = 1;
    #1;
    chk("flush_in_ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 0;
    #1;
    chk("flush_in_ready_after", 32'(in_ready), 32'd1);
    n = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (out_valid) n++;
    end
    chk("flush_no_output", 32'(n), 32'd0);
    // Reset in the middle of a shift
    run("rst_op", OPI, 3'd5, FB, 32'h80000000, 32'd0, 32'd20, 32'd0, 1'b0, 0, 0, 1);
    repeat (3) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_illegal", 32'(illegal), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      #1;
      if (out_valid) n++;
    end
    chk("midrst_no_output", 32'(n), 32'd0);
    // Barrel-shifter instance
    bar_run("bar_srai", OPI, 3'd5, FB, 32'h80000000, 32'd0, 32'h404, 32'hF8000000);
    bar_run("bar_sll", OPR, 3'd1, FB, 32'd1, 32'd31, 32'd0, 32'h80000000);
    bar_run("bar_srl", OPR, 3'd5, FB, 32'hF0, 32'd4, 32'd0, 32'h0F);
    bar_run("bar_sra", OPR, 3'd5, FA, 32'hFFFFFF00, 32'd8, 32'd0, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    #4;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("bar_q_drained", 32'(bar_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
